// File: rtl/axi_stream_packet_sink.sv
// AXI-Stream packet sink: accepts beats with optional LFSR backpressure, accumulates
// per-packet beat/byte counts and an XOR checksum, and flags keep/length errors.
module axi_stream_packet_sink #(
    parameter int unsigned DATA_WD      = 32,
    parameter int unsigned DATA_BYTE_WD = DATA_WD / 8,
    parameter int unsigned MAX_BEATS    = 64,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    bp_en,
    input  logic                    axi_tvalid,
    input  logic                    axi_tlast,
    input  logic [DATA_BYTE_WD-1:0] axi_keep,
    input  logic [DATA_WD-1:0]      axi_tdata,
    output logic                    axi_tready,
    output logic                    pkt_done,
    output logic [15:0]             pkt_beats,
    output logic [15:0]             pkt_bytes,
    output logic [DATA_WD-1:0]      pkt_csum,
    output logic                    err_keep,
    output logic                    err_len,
    output logic [15:0]             pkt_count
);

    typedef enum logic [1:0] {IDLE, ACTIVE, REPORT} state_t;

    state_t               state, state_nxt;
    logic [15:0]          lfsr;
    logic [15:0]          beats_acc, bytes_acc;
    logic [DATA_WD-1:0]   csum_acc;
    logic [15:0]          base_beats, base_bytes, beat_bytes;
    logic [DATA_WD-1:0]   base_csum, beat_data;
    logic [15:0]          beats_nxt, bytes_nxt;
    logic [16:0]          bytes_sum;
    logic [DATA_WD-1:0]   csum_nxt;
    logic [DATA_BYTE_WD-1:0] keep_low, keep_run;
    logic                 accept, last_ok, keep_bad, len_bad;

    assign axi_tready = (state != REPORT) && (!bp_en || lfsr[0]);
    assign accept     = axi_tvalid && axi_tready;

    // Byte-masked payload and keep popcount of the current beat
    always_comb begin
        beat_bytes = '0;
        beat_data  = '0;
        for (int i = 0; i < int'(DATA_BYTE_WD); i++) begin
            beat_bytes = beat_bytes + 16'(axi_keep[i]);
            beat_data[i*8 +: 8] = axi_keep[i] ? axi_tdata[i*8 +: 8] : 8'h00;
        end
    end

    // Adding the lowest set bit clears a run of ones only if that run is the whole mask
    assign keep_low = axi_keep & (~axi_keep + DATA_BYTE_WD'(1));
    assign keep_run = axi_keep + keep_low;
    assign last_ok  = (axi_keep != '0) && ((keep_run & axi_keep) == '0);
    assign keep_bad = axi_tlast ? !last_ok : (axi_keep != '1);
    assign len_bad  = (state == ACTIVE) && !axi_tlast && (32'(beats_acc) >= 32'(MAX_BEATS));

    always_comb begin
        base_beats = (state == IDLE) ? 16'h0 : beats_acc;
        base_bytes = (state == IDLE) ? 16'h0 : bytes_acc;
        base_csum  = (state == IDLE) ? '0 : csum_acc;
        beats_nxt  = (base_beats == 16'hFFFF) ? 16'hFFFF : base_beats + 16'h1;
        bytes_sum  = {1'b0, base_bytes} + {1'b0, beat_bytes};
        bytes_nxt  = bytes_sum[16] ? 16'hFFFF : bytes_sum[15:0];
        csum_nxt   = base_csum ^ beat_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = axi_tlast ? REPORT : ACTIVE;
            ACTIVE:  if (accept && (axi_tlast || len_bad)) state_nxt = REPORT;
            REPORT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr      <= LFSR_SEED;
            beats_acc <= '0;
            bytes_acc <= '0;
            csum_acc  <= '0;
            pkt_done  <= 1'b0;
            pkt_beats <= '0;
            pkt_bytes <= '0;
            pkt_csum  <= '0;
            err_keep  <= 1'b0;
            err_len   <= 1'b0;
            pkt_count <= '0;
        end else begin
            if (bp_en) lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
            if (accept) begin
                beats_acc <= beats_nxt;
                bytes_acc <= bytes_nxt;
                csum_acc  <= csum_nxt;
                if (keep_bad) err_keep <= 1'b1;
                if (len_bad)  err_len  <= 1'b1;
            end
            pkt_done <= (state_nxt == REPORT);
            if (state != REPORT && state_nxt == REPORT) begin
                pkt_beats <= beats_nxt;
                pkt_bytes <= bytes_nxt;
                pkt_csum  <= csum_nxt;
            end
            if (state == REPORT) pkt_count <= pkt_count + 16'h1;
        end
    end

endmodule

// File: doc/axi_stream_packet_sink.md
Name: axi_stream_packet_sink

Overview:
Receiving end of the team's AXI-Stream packet interface; consumes the stream driven by the packet generators. Drives tready, with optional pseudo-random backpressure. Accepts beats, accumulates per-packet beat count, byte count (from keep) and an XOR checksum. Flags keep/length protocol errors and reports per-packet results to the test bench or status registers.

Parameters:
DATA_WD, 32, data width in bits (multiple of 8)
DATA_BYTE_WD, DATA_WD/8, keep width
MAX_BEATS, 64, beats allowed per packet before an overlength error
LFSR_SEED, 16'hACE1, backpressure LFSR reset value (must be nonzero)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  reset, asynchronous, active-high
bp_en  in  1  1 = tready follows LFSR bit 0; 0 = tready high whenever state allows
axi_tvalid  in  1  source beat valid
axi_tlast  in  1  last beat of packet
axi_keep  in  DATA_BYTE_WD  byte enables
axi_tdata  in  DATA_WD  payload
axi_tready  out  1  sink ready
pkt_done  out  1  one-cycle pulse: report outputs valid
pkt_beats  out  16  beats in reported packet
pkt_bytes  out  16  bytes in reported packet (sum of keep popcounts)
pkt_csum  out  DATA_WD  XOR of keep-masked tdata of all beats in packet
err_keep  out  1  sticky: illegal keep seen
err_len  out  1  sticky: packet exceeded MAX_BEATS
pkt_count  out  16  packets reported since reset, wraps 16'hFFFF->0

Behaviour:
- Reset (async, rst=1): state IDLE, all outputs 0, LFSR=LFSR_SEED, accumulators 0. Deassertion is synchronous to clk.
- Beat accepted when axi_tvalid & axi_tready are high at a rising edge. Nothing is sampled otherwise; tready does not wait for tvalid.
- axi_tready = (state != REPORT) & (!bp_en | lfsr[0]).
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Shifts every cycle while bp_en=1 and holds otherwise.
- States:
  - IDLE: no beat of current packet yet. On accepted beat, load accumulators from that beat. tlast=1 -> REPORT; else -> ACTIVE.
  - ACTIVE: accumulate each accepted beat. tlast=1 -> REPORT. If the accepted beat would be beat MAX_BEATS+1 without tlast, set err_len, close the packet with that beat included, and go to REPORT.
  - REPORT: lasts exactly one cycle with tready=0. pkt_done=1; pkt_beats/pkt_bytes/pkt_csum hold final values. pkt_count increments at the end of this cycle. Always -> IDLE.
- Report outputs hold their values until the next REPORT. pkt_done is high only during REPORT.
- Accumulation:
  - beats +1 per accepted beat.
  - bytes += popcount(keep).
  - csum ^= tdata with bytes where keep=0 forced to 0.
  - 16-bit counters saturate at 16'hFFFF.
- Keep legality, checked on every accepted beat:
  - Non-last beat: keep must be all ones.
  - Last beat: keep must be nonzero and a single contiguous run of ones (e.g. 1111, 1110, 1100, 0011, 0110 legal; 0101, 0000 illegal).
  - Any violation sets err_keep. The beat is still accepted and counted.
- err_keep and err_len are sticky until reset.
- tvalid high with tready low: the sink takes no action and has no protocol obligation on the source's data.
- Reset mid-packet: the partial packet is discarded, no pkt_done is generated, and pkt_count is not incremented.
- Packet latency: pkt_done asserts the cycle after the tlast beat is accepted.

Test Plan:
- bp_en=0; 4-beat packet, data 1,2,4,8, keep 1111 all beats, tlast on beat 4 -> tready constant 1; pkt_done one cycle after beat 4; pkt_beats=4, pkt_bytes=16, pkt_csum=32'h0000000F, pkt_count=1, no errors; tready=0 during REPORT only.
- Single-beat packet, tdata=32'hAABBCCDD, keep=1100, tlast=1 -> pkt_beats=1, pkt_bytes=2, pkt_csum=32'hAABB0000.
- 3-beat packet with beat 2 keep=0111 (not last), last keep=0101 -> err_keep=1 after beat 2 and remains set; pkt_beats=3 still reported.
- MAX_BEATS=4; 6 beats, no tlast -> err_len=1; pkt_done after 5th accepted beat, pkt_beats=5. 6th beat starts a new packet in IDLE.
- bp_en=1, source holds tvalid for 10-beat packet -> tready matches LFSR bit 0 sequence from LFSR_SEED; results identical to bp_en=0 run; no beat lost or duplicated.
- rst pulse after beat 2 of a 5-beat packet -> outputs 0 immediately (asynchronously); next full packet reports its own values only, pkt_count=1.
